// File: rtl/onehot_seq_if.sv
// Bus bundle for onehot_seq: advance/hold controls in, one-hot state and status pulses out.
// With ONEHOT_SEQ_STR_EN defined the bundle also carries the 64-bit ASCII state name str.
interface onehot_seq_if #(
  parameter int unsigned N       = 3,
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned IW      = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]       adv;
  logic               hold;
  logic [N-1:0]       st;
  logic [IW-1:0]      state_idx;
  logic [DWELL_W-1:0] dwell;
  logic               entered;
  logic               timeout;
  logic               err;
`ifdef ONEHOT_SEQ_STR_EN
  logic [63:0]        str;

  modport master (output adv, hold,
                  input  st, state_idx, dwell, entered, timeout, err, str);
  modport slave  (input  adv, hold,
                  output st, state_idx, dwell, entered, timeout, err, str);
`else
  modport master (output adv, hold,
                  input  st, state_idx, dwell, entered, timeout, err);
  modport slave  (input  adv, hold,
                  output st, state_idx, dwell, entered, timeout, err);
`endif
endinterface

// File: rtl/onehot_seq.sv
// Parametrised one-hot ring sequencer with minimum dwell, optional timeout and illegal-state recovery.
// Define ONEHOT_SEQ_STR_EN to add the registered ASCII state name output str.
module onehot_seq #(
  parameter int unsigned N         = 3,
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned MIN_DWELL = 0,
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic        clock,
  input  logic        reset,
  onehot_seq_if.slave bus
);

  logic [N-1:0]       st_q, st_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               entered_q, entered_d;
  logic               timeout_q, timeout_d;
  logic               err_q, err_d;
  logic               legal;
  logic [IW-1:0]      cur_idx, nxt_idx;
  logic               adv_hit, dwell_ok, tmo_hit;

  // Decode the registered state; adv is only ever judged against st_q.
  always_comb begin
    cur_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (st_q[k]) cur_idx = IW'(k);
    end
    legal   = ($countones(st_q) == 1);
    adv_hit = |(bus.adv & st_q);
    if (32'(cur_idx) == N - 1) nxt_idx = '0;
    else                       nxt_idx = cur_idx + 1'b1;
  end

  if (MIN_DWELL == 0) begin : g_nomin
    assign dwell_ok = 1'b1;
  end else begin : g_min
    assign dwell_ok = (dwell_q >= DWELL_W'(MIN_DWELL));
  end

  if (TIMEOUT == 0) begin : g_notmo
    assign tmo_hit = 1'b0;
  end else begin : g_tmo
    assign tmo_hit = (dwell_q == DWELL_W'(TIMEOUT - 1));
  end

  // Next-state and pulse generation, in priority order.
  always_comb begin
    st_d      = st_q;
    dwell_d   = dwell_q;
    entered_d = 1'b0;
    timeout_d = 1'b0;
    err_d     = 1'b0;
    if (!legal) begin
      st_d      = N'(1);
      dwell_d   = '0;
      err_d     = 1'b1;
      entered_d = 1'b1;
    end else if (bus.hold) begin
      st_d      = st_q;
    end else if (adv_hit && dwell_ok) begin
      st_d      = N'(1) << nxt_idx;
      dwell_d   = '0;
      entered_d = 1'b1;
    end else if (tmo_hit) begin
      st_d      = N'(1);
      dwell_d   = '0;
      timeout_d = 1'b1;
      entered_d = 1'b1;
    end else if (dwell_q != '1) begin
      dwell_d   = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q      <= N'(1);
      dwell_q   <= '0;
      entered_q <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      dwell_q   <= dwell_d;
      entered_q <= entered_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.st        = st_q;
  assign bus.state_idx = legal ? cur_idx : '0;
  assign bus.dwell     = dwell_q;
  assign bus.entered   = entered_q;
  assign bus.timeout   = timeout_q;
  assign bus.err       = err_q;

`ifdef ONEHOT_SEQ_STR_EN
  logic [63:0] str_q, str_d;

  function automatic logic [63:0] state_name(input logic [IW-1:0] idx);
    logic [7:0] v;
    v = 8'(idx);
    return {"STATE_", 8'(8'h30 + v / 8'd10), 8'(8'h30 + v % 8'd10)};
  endfunction

  // The name follows whichever state st_d is about to enter.
  always_comb begin
    str_d = str_q;
    if (!legal)                       str_d = state_name('0);
    else if (bus.hold)                str_d = str_q;
    else if (adv_hit && dwell_ok)     str_d = state_name(nxt_idx);
    else if (tmo_hit)                 str_d = state_name('0);
  end

  always_ff @(posedge clock) begin
    if (reset) str_q <= state_name('0);
    else       str_q <= str_d;
  end

  assign bus.str = str_q;
`endif

endmodule
